dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters:
  - port P: the processor load/store path.
  - port L: a loader/DMA engine that preloads or dumps data memory.
- Sits between the requesters and the dmem instance; drives dmem address, data and wren.
- Round-robin arbitration, with an optional bounded lock that lets L perform bursts.
- Read data is returned to the requester that issued the read, tagged with a valid pulse.

Parameters:
- ADDR_W, 12: dmem address width.
- DATA_W, 32: dmem data width.
- RD_LAT, 1: cycles from dmem address/wren registered to q_dmem valid. Legal range 1–3.
- MAX_LOCK, 16: maximum consecutive L grants under lock while P is requesting.

Ports:
- clock  in  1  single clock; same domain as dmem_clock.
- reset  in  1  asynchronous, active-low reset.
- p_req  in  1  processor access request.
- p_we  in  1  processor write (1) / read (0).
- p_addr  in  ADDR_W  processor address.
- p_wdata  in  DATA_W  processor write data.
- p_gnt  out  1  processor request accepted this cycle.
- p_rvalid  out  1  p_rdata valid.
- p_rdata  out  DATA_W  processor read data.
- l_req  in  1  loader request.
- l_lock  in  1  loader asks to keep ownership on following cycles.
- l_we  in  1  loader write / read.
- l_addr  in  ADDR_W  loader address.
- l_wdata  in  DATA_W  loader write data.
- l_gnt  out  1  loader request accepted.
- l_rvalid  out  1  l_rdata valid.
- l_rdata  out  DATA_W  loader read data.
- address_dmem  out  ADDR_W  to dmem.
- data  out  DATA_W  to dmem.
- wren  out  1  to dmem.
- q_dmem  in  DATA_W  from dmem.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears address_dmem, data, wren, p_gnt, l_gnt, p_rvalid, l_rvalid, p_rdata, l_rdata to 0.
  - Priority pointer set to P; lock counter cleared to 0; read-return pipeline cleared.
  - Reads in flight when reset asserts are dropped: no rvalid is ever produced for them.
- Grant (combinational from p_req, l_req, l_lock and registered state); at most one of p_gnt/l_gnt is high in any cycle:
  - Only one requester asserting req: that requester is granted.
  - Both requesting, default: grant goes to the pointer's owner.
  - Both requesting, lock: L is granted when it was granted last cycle, l_lock=1, and the lock counter < MAX_LOCK.
- Pointer: after each grant, the pointer moves to the requester that did not win.
- Lock counter:
  - Increments on each L grant made while P is requesting.
  - Clears on any P grant, on any idle cycle, and on an L grant with l_lock=0.
  - When the counter reaches MAX_LOCK, P wins the next contended cycle regardless of l_lock.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt=1.
  - The access is accepted on the clock edge where gnt=1.
  - The requester may present a new request in the following cycle.
- Issue:
  - On the accepting edge, the winner's addr/wdata/we are registered onto address_dmem/data/wren.
  - wren is a 1-cycle pulse per write.
  - No grant: wren=0; address_dmem and data hold their previous values.
- Read return:
  - Each accepted read pushes its owner tag into an RD_LAT+1 deep shift pipeline.
  - Exactly RD_LAT+1 edges after the accepting edge, the owner's rvalid pulses for 1 cycle and its rdata captures q_dmem.
  - rdata holds its value until the next rvalid for that port.
- Writes produce no rvalid.
- Back-to-back reads from alternating owners return in issue order with no bubbles.
- A same-address write followed by a read returns the new data; no internal bypass is needed, since the dmem access order is preserved.
- Throughput: one access per cycle sustained.

Test Plan:
- P-only read: p_req=1, p_addr=0x010, dmem[0x010]=0xDEADBEEF → p_gnt same cycle; address_dmem=0x010 next cycle; p_rvalid=1 with p_rdata=0xDEADBEEF exactly RD_LAT+1 cycles after the grant edge; l_* outputs stay 0.
- Contention, no lock: p_req and l_req held for 4 cycles after reset → grants alternate P,L,P,L; wren pulses only on write grants.
- Lock burst with MAX_LOCK=4: L previously granted, l_lock=1, P requesting → exactly 4 consecutive L grants while P requests, then p_gnt=1; the counter clears on that P grant.
- Mixed traffic: L writes 0x00000055 to 0x020, then P reads 0x020 in the next cycle → p_rdata=0x00000055; l_rvalid never asserts for the write.
- Pipelined reads: alternating P/L reads of 0x001..0x006 → each rvalid goes to the correct port, in order, with one result per cycle.
- Reset mid-read: assert reset the cycle after a P read grant → all outputs 0 immediately and no p_rvalid ever follows; after release, a P-only request is granted first (pointer=P).

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous dmem between the processor
// (port P) and a loader/DMA engine (port L).
//   clock, reset (async, active-low)
//   P side : p_req/p_we/p_addr/p_wdata in, p_gnt/p_rvalid/p_rdata out
//   L side : l_req/l_lock/l_we/l_addr/l_wdata in, l_gnt/l_rvalid/l_rdata out
//   dmem   : address_dmem/data/wren out (registered), q_dmem in
// Grants are combinational. Arbitration is round-robin, with a bounded lock
// that lets L hold the memory for bursts. Read data returns RD_LAT+1 edges
// after the accepting edge, on the port that issued the read.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              l_req,
  input  logic              l_lock,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam int unsigned CNT_W  = $clog2(MAX_LOCK + 1);
  localparam int unsigned PIPE_D = RD_LAT + 1;

  logic              ptr_q, ptr_d;          // 0: P has priority, 1: L
  logic              l_last_q, l_last_d;    // L was granted last cycle
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic [PIPE_D-1:0] pv_q, pv_d;            // read-in-flight flags
  logic [PIPE_D-1:0] po_q, po_d;            // read owner tags (1 = L)
  logic              p_rvalid_q, p_rvalid_d;
  logic              l_rvalid_q, l_rvalid_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
  logic              lock_hold;
  logic              rd_issue;

  // Grant decision; suppressed while reset is asserted so nothing is accepted.
  always_comb begin
    p_gnt     = 1'b0;
    l_gnt     = 1'b0;
    lock_hold = l_last_q && l_lock && (lock_cnt_q < CNT_W'(MAX_LOCK));
    if (reset) begin
      if (p_req && l_req) begin
        if (lock_hold || ptr_q) l_gnt = 1'b1;
        else                    p_gnt = 1'b1;
      end else begin
        p_gnt = p_req;
        l_gnt = l_req;
      end
    end
  end

  // Next-state: pointer, lock counter, dmem issue and read-return pipeline.
  always_comb begin
    ptr_d      = ptr_q;
    l_last_d   = l_gnt;
    lock_cnt_d = lock_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wren_d     = 1'b0;
    p_rdata_d  = p_rdata_q;
    l_rdata_d  = l_rdata_q;

    if (p_gnt)      ptr_d = 1'b1;
    else if (l_gnt) ptr_d = 1'b0;

    if (p_gnt || !(p_req || l_req)) begin
      lock_cnt_d = '0;
    end else if (l_gnt) begin
      if (!l_lock)
        lock_cnt_d = '0;
      else if (p_req && (lock_cnt_q < CNT_W'(MAX_LOCK)))
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end

    if (p_gnt) begin
      addr_d = p_addr;
      data_d = p_wdata;
      wren_d = p_we;
    end else if (l_gnt) begin
      addr_d = l_addr;
      data_d = l_wdata;
      wren_d = l_we;
    end

    rd_issue = (p_gnt && !p_we) || (l_gnt && !l_we);
    pv_d     = {pv_q[PIPE_D-2:0], rd_issue};
    po_d     = {po_q[PIPE_D-2:0], l_gnt};

    // Last stage lines up with q_dmem for the read issued RD_LAT+1 edges ago.
    p_rvalid_d = pv_q[PIPE_D-1] && !po_q[PIPE_D-1];
    l_rvalid_d = pv_q[PIPE_D-1] &&  po_q[PIPE_D-1];
    if (p_rvalid_d) p_rdata_d = q_dmem;
    if (l_rvalid_d) l_rdata_d = q_dmem;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q      <= 1'b0;
      l_last_q   <= 1'b0;
      lock_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      pv_q       <= '0;
      po_q       <= '0;
      p_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      p_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      l_last_q   <= l_last_d;
      lock_cnt_q <= lock_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      pv_q       <= pv_d;
      po_q       <= po_d;
      p_rvalid_q <= p_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      p_rdata_q  <= p_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign address_dmem = addr_q;
  assign data         = data_q;
  assign wren         = wren_q;
  assign p_rvalid     = p_rvalid_q;
  assign l_rvalid     = l_rvalid_q;
  assign p_rdata      = p_rdata_q;
  assign l_rdata      = l_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vectors with explicit expected grants;
// read results are queued per port and checked by an independent monitor.
module tb_dmem_arbiter;

  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned MAX_LOCK = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p_req = 1'b0, p_we = 1'b0;
  logic [11:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic        l_req = 1'b0, l_lock = 1'b0, l_we = 1'b0;
  logic [11:0] l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic        p_gnt, p_rvalid, l_gnt, l_rvalid, wren;
  logic [31:0] p_rdata, l_rdata, data, q_dmem;
  logic [11:0] address_dmem;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;
  exp_t pq[$];
  exp_t lq[$];

  logic [31:0] ref_mem [0:4095];

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .l_req(l_req), .l_lock(l_lock), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(a));
  endfunction

  // Synchronous dmem: address registered, then RD_LAT-1 output register stages.
  logic [31:0] dm [0:4095];
  logic        dm_wr [0:4095];
  logic [11:0] ra = '0;
  logic [31:0] qr = '0;
  always @(posedge clock) begin
    if (wren) begin
      dm[address_dmem]    <= data;
      dm_wr[address_dmem] <= 1'b1;
    end
    ra <= address_dmem;
    qr <= (dm_wr[ra] === 1'b1) ? dm[ra] : init_val(ra);
  end
  assign q_dmem = qr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vec++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_address_dmem"}, 32'(address_dmem), 32'h0);
    chk({tag, "_data"},         data,              32'h0);
    chk({tag, "_wren"},         32'(wren),         32'h0);
    chk({tag, "_p_gnt"},        32'(p_gnt),        32'h0);
    chk({tag, "_l_gnt"},        32'(l_gnt),        32'h0);
    chk({tag, "_p_rvalid"},     32'(p_rvalid),     32'h0);
    chk({tag, "_l_rvalid"},     32'(l_rvalid),     32'h0);
    chk({tag, "_p_rdata"},      p_rdata,           32'h0);
    chk({tag, "_l_rdata"},      l_rdata,           32'h0);
  endtask

  // One cycle: drive requests, check grants, queue expected reads, check issue.
  task automatic step(input logic preq, input logic pwe, input logic [11:0] paddr,
                      input logic [31:0] pwd, input logic lreq, input logic llock,
                      input logic lwe, input logic [11:0] laddr, input logic [31:0] lwd,
                      input logic epg, input logic elg);
    p_req = preq; p_we = pwe; p_addr = paddr; p_wdata = pwd;
    l_req = lreq; l_lock = llock; l_we = lwe; l_addr = laddr; l_wdata = lwd;
    #1;
    chk("p_gnt", 32'(p_gnt), 32'(epg));
    chk("l_gnt", 32'(l_gnt), 32'(elg));
    if (epg) begin
      if (pwe) ref_mem[paddr] = pwd;
      else     pq.push_back('{ref_mem[paddr], cyc + 1 + int'(RD_LAT) + 1});
    end
    if (elg) begin
      if (lwe) ref_mem[laddr] = lwd;
      else     lq.push_back('{ref_mem[laddr], cyc + 1 + int'(RD_LAT) + 1});
    end
    @(posedge clock);
    #1;
    chk("wren", 32'(wren), 32'((epg && pwe) || (elg && lwe)));
    if (epg) begin
      chk("addr_p", 32'(address_dmem), 32'(paddr));
      if (pwe) chk("data_p", data, pwd);
    end
    if (elg) begin
      chk("addr_l", 32'(address_dmem), 32'(laddr));
      if (lwe) chk("data_l", data, lwd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0);
  endtask

  // Read-return monitor.
  always @(negedge clock) begin
    exp_t e;
    if (p_rvalid) begin
      if (pq.size() == 0) begin
        vec++; errs++;
        $display("FAIL p_rvalid_spurious actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = pq.pop_front();
        chk("p_rdata", p_rdata, e.dat);
        chk("p_rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (l_rvalid) begin
      if (lq.size() == 0) begin
        vec++; errs++;
        $display("FAIL l_rvalid_spurious actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = lq.pop_front();
        chk("l_rdata", l_rdata, e.dat);
        chk("l_rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    reset = 1'b1;

    // Contention without lock: P,L,P,L then P alone.
    step(1, 0, 12'h040, 32'h0,  1, 0, 1, 12'h050, 32'h22, 1, 0);
    step(1, 1, 12'h041, 32'h11, 1, 0, 1, 12'h050, 32'h22, 0, 1);
    step(1, 1, 12'h041, 32'h11, 1, 0, 0, 12'h050, 32'h0,  1, 0);
    step(1, 0, 12'h041, 32'h0,  1, 0, 0, 12'h050, 32'h0,  0, 1);
    step(1, 0, 12'h041, 32'h0,  0, 0, 0, 12'h000, 32'h0,  1, 0);
    idle(4);

    // P-only read of preloaded 0x010.
    step(1, 0, 12'h010, 32'h0, 0, 0, 0, 12'h000, 32'h0, 1, 0);
    idle(4);

    // L write then P read of the same address.
    step(0, 0, 12'h000, 32'h0, 1, 0, 1, 12'h020, 32'h55, 0, 1);
    step(1, 0, 12'h020, 32'h0, 0, 0, 0, 12'h000, 32'h0,  1, 0);
    idle(4);

    // Pipelined alternating reads 0x001..0x006.
    for (int i = 1; i <= 6; i++) begin
      if (i % 2 == 1) step(1, 0, 12'(i), 32'h0, 0, 0, 0, 12'h000, 32'h0, 1, 0);
      else            step(0, 0, 12'h000, 32'h0, 1, 0, 0, 12'(i), 32'h0, 0, 1);
    end
    idle(4);

    // Lock burst: L alone, then MAX_LOCK L grants under contention, then P.
    step(0, 0, 12'h000, 32'h0, 1, 1, 1, 12'h100, 32'h1, 0, 1);
    for (int i = 0; i < int'(MAX_LOCK); i++)
      step(1, 0, 12'h101, 32'h0, 1, 1, 1, 12'(32'h102 + i), 32'(i + 2), 0, 1);
    step(1, 0, 12'h101, 32'h0, 1, 1, 1, 12'h106, 32'h6, 1, 0);
    // Counter cleared by the P grant: L may lock again.
    step(0, 0, 12'h000, 32'h0, 1, 1, 1, 12'h106, 32'h6, 0, 1);
    step(1, 0, 12'h102, 32'h0, 1, 1, 1, 12'h107, 32'h7, 0, 1);
    step(1, 0, 12'h102, 32'h0, 1, 0, 1, 12'h108, 32'h8, 1, 0);
    idle(4);

    // Reset the cycle after a P read grant; that read must never return.
    step(1, 0, 12'h200, 32'h0, 0, 0, 0, 12'h000, 32'h0, 1, 0);
    p_req = 1'b1;
    reset = 1'b0;
    #1;
    chk_zero("midreset");
    pq.delete();
    p_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    step(1, 0, 12'h003, 32'h0, 1, 0, 0, 12'h004, 32'h0, 1, 0);
    step(0, 0, 12'h000, 32'h0, 1, 0, 0, 12'h004, 32'h0, 0, 1);
    idle(5);

    for (int i = 0; i < 20; i++) begin
      if (pq.size() == 0 && lq.size() == 0) break;
      @(posedge clock);
    end
    if (pq.size() != 0 || lq.size() != 0) begin
      vec++; errs++;
      $display("FAIL rvalid_timeout actual=%0d/%0d pending required=0/0", pq.size(), lq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
